spc_io_timers: RTL



---
 rtl/spc_io_pkg.sv | 24 ++
 rtl/spc_timer_channel.sv | 50 +++++
 rtl/spc_io_timers.sv | 113 +++++++++++
 3 files changed

// File: rtl/spc_io_pkg.sv
// Shared addresses, widths and helpers for the SPC700 I/O page and timers.
package spc_io_pkg;

    localparam logic [15:0] IO_PAGE_BASE = 16'h00F0;
    localparam logic [15:0] IO_CONTROL   = 16'h00F1;
    localparam logic [15:0] IO_TARGET0   = 16'h00FA;
    localparam logic [15:0] IO_TARGET1   = 16'h00FB;
    localparam logic [15:0] IO_TARGET2   = 16'h00FC;
    localparam logic [15:0] IO_COUNTER0  = 16'h00FD;
    localparam logic [15:0] IO_COUNTER1  = 16'h00FE;
    localparam logic [15:0] IO_COUNTER2  = 16'h00FF;

    localparam int CNT_W      = 4;
    localparam int STAGE_W    = 8;
    localparam int NUM_TIMERS = 3;

    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [STAGE_W-1:0] stage_t;

    function automatic logic in_io_page(input logic [15:0] addr);
        return addr[15:4] == IO_PAGE_BASE[15:4];
    endfunction

endpackage

// File: rtl/spc_timer_channel.sv
// One SPC700 timer: 8-bit stage divider feeding a 4-bit wrapping output counter.
// Registered update; enable rising edge clears both counters and discards a coincident tick.
module spc_timer_channel
    import spc_io_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   enable,
    input  logic   tick,
    input  stage_t target,
    input  logic   clear_req,
    output cnt_t   cnt
);

    logic   enable_q;
    stage_t stage;
    stage_t stage_inc;
    logic   match;
    logic   bump;

    // Target 0 matches when stage_inc wraps to 0, giving a 256-tick period.
    assign stage_inc = stage + 8'd1;
    assign match     = (stage_inc == target);
    assign bump      = enable && tick && match;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enable_q <= 1'b0;
            stage    <= '0;
            cnt      <= '0;
        end else begin
            enable_q <= enable;
            if (enable && !enable_q) begin
                stage <= '0;
                cnt   <= '0;
            end else begin
                if (enable && tick) begin
                    stage <= match ? '0 : stage_inc;
                end
                // A read-clear never swallows an increment landing on the same edge.
                if (clear_req) begin
                    cnt <= bump ? cnt_t'(1) : '0;
                end else if (bump) begin
                    cnt <= cnt + cnt_t'(1);
                end
            end
        end
    end

endmodule

// File: rtl/spc_io_timers.sv
// $F0-$FF I/O page snooping the CPU bus: CONTROL/TARGET writes, COUNTER reads, three timers.
// Read data and hit are registered one cycle after the address, matching synchronous RAM.
module spc_io_timers
    import spc_io_pkg::*;
#(
    parameter int T01_DIV = 256,
    parameter int T2_DIV  = 32
)(
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] in_ram_address,
    input  logic [7:0]  in_ram_write,
    input  logic        in_ram_write_enable,
    output logic [7:0]  out_io_read,
    output logic        out_io_hit
);

    localparam int P01_W = $clog2(T01_DIV);
    localparam int P2_W  = $clog2(T2_DIV);

    logic [P01_W-1:0]      presc;
    logic                  tick01;
    logic                  tick2;
    logic [NUM_TIMERS-1:0] control;
    stage_t                target [NUM_TIMERS];
    cnt_t                  cnt    [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] clear_req;
    logic [15:0]           prev_address;
    logic                  prev_write;
    logic                  in_page;
    logic                  read_access;
    logic                  first;
    logic [7:0]            read_dat;

    assign tick01 = &presc;
    assign tick2  = &presc[P2_W-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else begin
            presc <= presc + P01_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            control <= '0;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                target[i] <= '0;
            end
        end else if (in_ram_write_enable) begin
            case (in_ram_address)
                IO_CONTROL: control   <= in_ram_write[NUM_TIMERS-1:0];
                IO_TARGET0: target[0] <= in_ram_write;
                IO_TARGET1: target[1] <= in_ram_write;
                IO_TARGET2: target[2] <= in_ram_write;
                default: ;
            endcase
        end
    end

    // A read access starts when the address changes or the previous cycle was a write.
    assign in_page     = in_io_page(in_ram_address);
    assign read_access = in_page && !in_ram_write_enable;
    assign first       = !in_ram_write_enable &&
                         ((in_ram_address != prev_address) || prev_write);

    genvar g;
    generate
        for (g = 0; g < NUM_TIMERS; g++) begin : g_ch
            assign clear_req[g] = first && (in_ram_address == IO_COUNTER0 + 16'(g));

            spc_timer_channel u_ch (
                .clock     (clock),
                .reset     (reset),
                .enable    (control[g]),
                .tick      ((g == 2) ? tick2 : tick01),
                .target    (target[g]),
                .clear_req (clear_req[g]),
                .cnt       (cnt[g])
            );
        end
    endgenerate

    always_comb begin
        read_dat = '0;
        case (in_ram_address)
            IO_COUNTER0: read_dat = {{(8-CNT_W){1'b0}}, cnt[0]};
            IO_COUNTER1: read_dat = {{(8-CNT_W){1'b0}}, cnt[1]};
            IO_COUNTER2: read_dat = {{(8-CNT_W){1'b0}}, cnt[2]};
            default:     read_dat = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_io_read  <= '0;
            out_io_hit   <= 1'b0;
            prev_address <= 16'hFFFF;
            prev_write   <= 1'b0;
        end else begin
            prev_address <= in_ram_address;
            prev_write   <= in_ram_write_enable;
            out_io_hit   <= read_access;
            // A held read keeps returning the value captured before its clear.
            if (!(read_access && !first)) begin
                out_io_read <= read_dat;
            end
        end
    end

endmodule
